// File: rtl/video_ram_arbiter_if.sv
// rtl/video_ram_arbiter_if.sv - writer, display and RAM signal bundle for the video RAM arbiter
//
// Purpose: groups the pixel-writer stream, the display read port and the frame RAM port.
// Ports (as seen by the arbiter through the slave modport):
//   wr_valid/wr_pixel/wr_sof in, wr_ready out       pixel writer handshake
//   rd_req/rd_addr in, rd_valid/rd_data out          display scan-out reads
//   ram_addr/ram_we/ram_wdata out, ram_rdata in      single-port frame RAM
//   frame_done out, fifo_level out                   status
interface video_ram_arbiter_if #(
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 4
);
  logic                          wr_valid;
  logic                          wr_ready;
  logic [1:0]                    wr_pixel;
  logic                          wr_sof;
  logic                          rd_req;
  logic [ADDR_W-1:0]             rd_addr;
  logic                          rd_valid;
  logic [1:0]                    rd_data;
  logic [ADDR_W-1:0]             ram_addr;
  logic                          ram_we;
  logic [1:0]                    ram_wdata;
  logic [1:0]                    ram_rdata;
  logic                          frame_done;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;

  modport master (
    output wr_valid, wr_pixel, wr_sof, rd_req, rd_addr, ram_rdata,
    input  wr_ready, rd_valid, rd_data, ram_addr, ram_we, ram_wdata, frame_done, fifo_level
  );

  modport slave (
    input  wr_valid, wr_pixel, wr_sof, rd_req, rd_addr, ram_rdata,
    output wr_ready, rd_valid, rd_data, ram_addr, ram_we, ram_wdata, frame_done, fifo_level
  );
endinterface

// File: rtl/video_ram_arbiter.sv
// rtl/video_ram_arbiter.sv - shares one single-port frame RAM between pixel writer and display reader
//
// Purpose: display reads always own the RAM slot; writer pixels queue in a small FIFO and
// drain into slots the display does not need. A one-entry read cache turns repeated reads
// of the same address (3x upscaling) into free slots.
// Ports:
//   pclk  in   single clock, posedge
//   rst   in   asynchronous active-high reset
//   bus   slave modport of video_ram_arbiter_if (writer stream, display reads, RAM port,
//         frame_done pulse, fifo_level)
module video_ram_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int FB_PIXELS  = 23040,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   pclk,
  input  logic                   rst,
  video_ram_arbiter_if.slave     bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_PIXELS - 1);

  // writer FIFO, entry = {sof, pixel}
  logic [2:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  fifo_wptr, fifo_rptr;
  logic [LVL_W-1:0]  level;

  logic [ADDR_W-1:0] wr_addr;

  logic              cache_valid;
  logic [ADDR_W-1:0] cache_addr;
  logic [1:0]        cache_data;

  // two-stage read pipeline; hit and miss share the same latency
  logic              s1_valid, s1_hit;
  logic [1:0]        s1_data;
  logic [ADDR_W-1:0] s1_addr;
  logic              s2_valid, s2_hit, s2_written;
  logic [1:0]        s2_data;
  logic [ADDR_W-1:0] s2_addr;

  logic [ADDR_W-1:0] ram_addr_q;
  logic              ram_we_q;
  logic [1:0]        ram_wdata_q;
  logic              rd_valid_q;
  logic [1:0]        rd_data_q;
  logic              frame_done_q;

  logic              push, pop, hit, miss;
  logic [2:0]        head;
  logic [ADDR_W-1:0] issue_addr, next_wr_addr;
  logic              nxt_cache_valid;
  logic [ADDR_W-1:0] nxt_cache_addr;
  logic [1:0]        nxt_cache_data;

  assign bus.wr_ready   = (level < LVL_W'(FIFO_DEPTH));
  assign bus.fifo_level = level;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.frame_done = frame_done_q;

  assign push = bus.wr_valid && bus.wr_ready;
  assign hit  = bus.rd_req && cache_valid && (bus.rd_addr == cache_addr);
  assign miss = bus.rd_req && !hit;
  // level is the pre-edge occupancy, so a pixel pushed this edge is never popped this edge
  assign pop  = !miss && (level != '0);

  assign head         = fifo_mem[fifo_rptr];
  assign issue_addr   = head[2] ? '0 : wr_addr;
  assign next_wr_addr = (issue_addr == LAST_ADDR) ? '0 : issue_addr + ADDR_W'(1);

  // Miss fill, then write coherence. A fill whose address was written one edge after the
  // read carries pre-write RAM data and is dropped. A write landing on the same edge as a
  // fill overrides the (equally stale) fill data.
  always_comb begin
    nxt_cache_valid = cache_valid;
    nxt_cache_addr  = cache_addr;
    nxt_cache_data  = cache_data;
    if (s2_valid && !s2_hit) begin
      if (s2_written) begin
        nxt_cache_valid = 1'b0;
      end else begin
        nxt_cache_valid = 1'b1;
        nxt_cache_addr  = s2_addr;
        nxt_cache_data  = bus.ram_rdata;
      end
    end
    if (pop && nxt_cache_valid && (issue_addr == nxt_cache_addr)) begin
      nxt_cache_data = head[1:0];
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers and level
  always_ff @(posedge pclk) begin
    if (push) begin
      fifo_mem[fifo_wptr] <= {bus.wr_sof, bus.wr_pixel};
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      fifo_wptr    <= '0;
      fifo_rptr    <= '0;
      level        <= '0;
      wr_addr      <= '0;
      cache_valid  <= 1'b0;
      cache_addr   <= '0;
      cache_data   <= '0;
      s1_valid     <= 1'b0;
      s1_hit       <= 1'b0;
      s1_data      <= '0;
      s1_addr      <= '0;
      s2_valid     <= 1'b0;
      s2_hit       <= 1'b0;
      s2_written   <= 1'b0;
      s2_data      <= '0;
      s2_addr      <= '0;
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_wdata_q  <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      if (push) fifo_wptr <= fifo_wptr + PTR_W'(1);
      if (pop)  fifo_rptr <= fifo_rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase

      if (miss) begin
        ram_addr_q <= bus.rd_addr;
        ram_we_q   <= 1'b0;
      end else if (pop) begin
        ram_addr_q  <= issue_addr;
        ram_we_q    <= 1'b1;
        ram_wdata_q <= head[1:0];
        wr_addr     <= next_wr_addr;
      end else begin
        ram_we_q <= 1'b0;
      end
      frame_done_q <= pop && (issue_addr == LAST_ADDR);

      s1_valid   <= bus.rd_req;
      s1_hit     <= hit;
      s1_data    <= cache_data;
      s1_addr    <= bus.rd_addr;
      s2_valid   <= s1_valid;
      s2_hit     <= s1_hit;
      s2_data    <= s1_data;
      s2_addr    <= s1_addr;
      s2_written <= pop && (issue_addr == s1_addr);

      rd_valid_q <= s2_valid;
      if (s2_valid) rd_data_q <= s2_hit ? s2_data : bus.ram_rdata;

      cache_valid <= nxt_cache_valid;
      cache_addr  <= nxt_cache_addr;
      cache_data  <= nxt_cache_data;
    end
  end
endmodule

// File: tb/tb_video_ram_arbiter.sv
// tb/tb_video_ram_arbiter.sv - directed self-checking bench for video_ram_arbiter
module tb_video_ram_arbiter;
  logic pclk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   rv_cnt = 0;
  int   fd_cnt = 0;
  logic [16:0] wlog [$];
  logic [1:0]  mem [32768];
  logic [1:0]  t2_pix [4];

  always #5 pclk = ~pclk;

  video_ram_arbiter_if #(.ADDR_W(15), .FIFO_DEPTH(4)) bus ();

  video_ram_arbiter #(.ADDR_W(15), .FB_PIXELS(23040), .FIFO_DEPTH(4)) dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus)
  );

  // frame RAM model: 1-cycle read latency, read-before-write
  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = i[1:0];
    mem[100] = 2'd2;
  end

  always @(posedge pclk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  always @(posedge pclk) begin
    if (bus.ram_we)     wlog.push_back({bus.ram_addr, bus.ram_wdata});
    if (bus.rd_valid)   rv_cnt++;
    if (bus.frame_done) fd_cnt++;
  end

  task automatic tick;
    @(negedge pclk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    t2_pix = '{2'd2, 2'd0, 2'd1, 2'd3};
    rst = 1'b1;
    bus.wr_valid = 1'b0; bus.wr_pixel = 2'd0; bus.wr_sof = 1'b0;
    bus.rd_req = 1'b0;   bus.rd_addr = '0;
    tick; tick;
    chk("rst_ram_addr",   32'(bus.ram_addr),   0);
    chk("rst_ram_we",     32'(bus.ram_we),     0);
    chk("rst_ram_wdata",  32'(bus.ram_wdata),  0);
    chk("rst_rd_valid",   32'(bus.rd_valid),   0);
    chk("rst_rd_data",    32'(bus.rd_data),    0);
    chk("rst_frame_done", 32'(bus.frame_done), 0);
    chk("rst_fifo_level", 32'(bus.fifo_level), 0);
    chk("rst_wr_ready",   32'(bus.wr_ready),   1);
    rst = 1'b0;
    tick;

    // T1: three pixels, no reads -> writes 0,1,2
    wlog.delete();
    bus.wr_valid = 1'b1; bus.wr_pixel = 2'd2; bus.wr_sof = 1'b1; tick;
    chk("t1_lvl_after_push", 32'(bus.fifo_level), 1);
    chk("t1_no_bypass",      32'(bus.ram_we), 0);
    bus.wr_pixel = 2'd1; bus.wr_sof = 1'b0; tick;
    chk("t1_w0", 32'({bus.ram_we, bus.ram_addr, bus.ram_wdata}), 32'({1'b1, 15'd0, 2'd2}));
    bus.wr_pixel = 2'd3; tick;
    chk("t1_w1", 32'({bus.ram_we, bus.ram_addr, bus.ram_wdata}), 32'({1'b1, 15'd1, 2'd1}));
    bus.wr_valid = 1'b0; tick;
    chk("t1_w2", 32'({bus.ram_we, bus.ram_addr, bus.ram_wdata}), 32'({1'b1, 15'd2, 2'd3}));
    chk("t1_lvl_empty", 32'(bus.fifo_level), 0);
    tick;
    chk("t1_idle_we",   32'(bus.ram_we), 0);
    chk("t1_idle_addr", 32'(bus.ram_addr), 2);
    chk("t1_wlog_n",    32'(wlog.size()), 3);

    // T2: misses every cycle starve the writer; drain after rd_req drops
    wlog.delete(); rv_cnt = 0;
    bus.rd_req = 1'b1; bus.wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.rd_addr  = 15'(200 + i);
      bus.wr_pixel = (i < 4) ? t2_pix[i] : 2'd0;
      tick;
      chk("t2_no_we", 32'(bus.ram_we), 0);
      if (i == 3) begin
        chk("t2_rd_valid", 32'(bus.rd_valid), 1);
        chk("t2_rd_data",  32'(bus.rd_data), 1);
      end
    end
    chk("t2_wr_ready_full", 32'(bus.wr_ready), 0);
    chk("t2_lvl_full",      32'(bus.fifo_level), 4);
    bus.rd_req = 1'b0; bus.wr_valid = 1'b0;
    tick;
    chk("t2_drain0_addr", 32'(bus.ram_addr), 3);
    chk("t2_drain0_lvl",  32'(bus.fifo_level), 3);
    tick; tick; tick; tick;
    chk("t2_wlog_n", 32'(wlog.size()), 4);
    for (int i = 0; i < 4; i++)
      chk("t2_drain_order", 32'(wlog[i]), 32'({15'(3 + i), t2_pix[i]}));
    chk("t2_lvl_end", 32'(bus.fifo_level), 0);
    chk("t2_rd_pulses", 32'(rv_cnt), 5);

    // T4b: miss on 7, write to 7 on the next edge -> old data, cache dropped
    bus.rd_req = 1'b1; bus.rd_addr = 15'd7; bus.wr_valid = 1'b1; bus.wr_pixel = 2'd0; tick;
    bus.rd_req = 1'b0; bus.wr_valid = 1'b0; tick;
    chk("t4b_write7", 32'({bus.ram_we, bus.ram_addr}), 32'({1'b1, 15'd7}));
    bus.wr_valid = 1'b1; bus.wr_pixel = 2'd2; tick;
    chk("t4b_rd_old", 32'({bus.rd_valid, bus.rd_data}), 32'({1'b1, 2'd3}));
    bus.wr_valid = 1'b0; bus.rd_req = 1'b1; bus.rd_addr = 15'd7; tick;
    chk("t4b_cache_invalid", 32'({bus.ram_we, bus.ram_addr}), 32'({1'b0, 15'd7}));
    bus.rd_req = 1'b0; tick;
    chk("t4b_pending_write", 32'({bus.ram_we, bus.ram_addr, bus.ram_wdata}), 32'({1'b1, 15'd8, 2'd2}));
    tick;
    chk("t4b_rd_new", 32'({bus.rd_valid, bus.rd_data}), 32'({1'b1, 2'd0}));

    // T4a: cache holds 9 = 01, write 11 to 9, then hit returns 11
    bus.rd_req = 1'b1; bus.rd_addr = 15'd9; tick;
    bus.rd_req = 1'b0; tick;
    bus.wr_valid = 1'b1; bus.wr_pixel = 2'd3; tick;
    chk("t4a_rd_miss", 32'({bus.rd_valid, bus.rd_data}), 32'({1'b1, 2'd1}));
    bus.wr_pixel = 2'd1; tick;
    chk("t4a_write9", 32'({bus.ram_we, bus.ram_addr, bus.ram_wdata}), 32'({1'b1, 15'd9, 2'd3}));
    bus.wr_valid = 1'b0; bus.rd_req = 1'b1; tick;
    chk("t4a_hit_frees_slot", 32'({bus.ram_we, bus.ram_addr}), 32'({1'b1, 15'd10}));
    bus.rd_req = 1'b0; tick;
    chk("t4a_no_early_valid", 32'(bus.rd_valid), 0);
    tick;
    chk("t4a_hit_data", 32'({bus.rd_valid, bus.rd_data}), 32'({1'b1, 2'd3}));

    // T3: miss on 100, then two hits; writer keeps pushing
    bus.rd_req = 1'b1; bus.rd_addr = 15'd100; bus.wr_valid = 1'b1; bus.wr_pixel = 2'd1; tick;
    chk("t3_miss_read", 32'({bus.ram_we, bus.ram_addr}), 32'({1'b0, 15'd100}));
    bus.rd_req = 1'b0; bus.wr_pixel = 2'd2; tick;
    bus.wr_pixel = 2'd3; tick;
    chk("t3_rd0", 32'({bus.rd_valid, bus.rd_data}), 32'({1'b1, 2'd2}));
    bus.rd_req = 1'b1; bus.wr_pixel = 2'd0; tick;
    chk("t3_hit1_write", 32'({bus.ram_we, bus.ram_addr}), 32'({1'b1, 15'd13}));
    bus.wr_pixel = 2'd1; tick;
    chk("t3_hit2_write", 32'({bus.ram_we, bus.ram_addr}), 32'({1'b1, 15'd14}));
    bus.rd_req = 1'b0; bus.wr_valid = 1'b0; tick;
    chk("t3_rd1", 32'({bus.rd_valid, bus.rd_data}), 32'({1'b1, 2'd2}));
    tick;
    chk("t3_rd2", 32'({bus.rd_valid, bus.rd_data}), 32'({1'b1, 2'd2}));
    tick;
    chk("t3_rd_done", 32'(bus.rd_valid), 0);

    // T5: full frame, wrap, mid-frame sof
    wlog.delete(); fd_cnt = 0;
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 23040; i++) begin
      bus.wr_pixel = i[1:0]; bus.wr_sof = (i == 0); tick;
    end
    bus.wr_pixel = 2'd1; bus.wr_sof = 1'b0; tick;
    chk("t5_last_addr",  32'(bus.ram_addr), 23039);
    chk("t5_frame_done", 32'(bus.frame_done), 1);
    for (int k = 1; k <= 500; k++) begin
      bus.wr_pixel = k[1:0]; tick;
      if (k == 1) begin
        chk("t5_wrap_addr", 32'({bus.ram_we, bus.ram_addr}), 32'({1'b1, 15'd0}));
        chk("t5_fd_single", 32'(bus.frame_done), 0);
      end
    end
    bus.wr_pixel = 2'd3; bus.wr_sof = 1'b1; tick;
    chk("t5_pix500_addr", 32'(bus.ram_addr), 500);
    bus.wr_valid = 1'b0; bus.wr_sof = 1'b0; tick;
    chk("t5_sof_addr", 32'({bus.ram_we, bus.ram_addr, bus.ram_wdata}), 32'({1'b1, 15'd0, 2'd3}));
    tick; tick;
    chk("t5_fd_count", 32'(fd_cnt), 1);
    chk("t5_wlog_n",   32'(wlog.size()), 23542);

    // T6: reset with FIFO at 3 and misses in flight
    bus.rd_req = 1'b1; bus.wr_valid = 1'b1;
    bus.rd_addr = 15'd300; bus.wr_pixel = 2'd1; bus.wr_sof = 1'b1; tick;
    bus.rd_addr = 15'd301; bus.wr_pixel = 2'd2; bus.wr_sof = 1'b0; tick;
    bus.rd_addr = 15'd302; bus.wr_pixel = 2'd3; tick;
    chk("t6_lvl_pre",   32'(bus.fifo_level), 3);
    chk("t6_valid_pre", 32'(bus.rd_valid), 1);
    rst = 1'b1; bus.rd_req = 1'b0; bus.wr_valid = 1'b0;
    #1;
    chk("t6_async_lvl",      32'(bus.fifo_level), 0);
    chk("t6_async_ready",    32'(bus.wr_ready), 1);
    chk("t6_async_rd_valid", 32'(bus.rd_valid), 0);
    chk("t6_async_ram_addr", 32'(bus.ram_addr), 0);
    rv_cnt = 0;
    tick; tick;
    rst = 1'b0;
    tick; tick; tick;
    chk("t6_no_stray_valid", 32'(rv_cnt), 0);
    chk("t6_we_idle",        32'(bus.ram_we), 0);
    bus.wr_valid = 1'b1; bus.wr_pixel = 2'd2; bus.wr_sof = 1'b1; tick;
    bus.wr_pixel = 2'd1; bus.wr_sof = 1'b0; tick;
    chk("t6_sof_addr0", 32'({bus.ram_we, bus.ram_addr, bus.ram_wdata}), 32'({1'b1, 15'd0, 2'd2}));
    bus.wr_valid = 1'b0; tick;
    chk("t6_next_addr1", 32'({bus.ram_we, bus.ram_addr, bus.ram_wdata}), 32'({1'b1, 15'd1, 2'd1}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
